// File: rtl/kf_pkg.sv
// Shared definitions for the Kalman-filter datapath and its frame sequencer.
package kf_pkg;

   localparam int unsigned KF_N    = 20;
   localparam int unsigned KF_FRAC = 10;
   localparam int          KF_ONE  = 1 <<< KF_FRAC;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_EMIT   = 2'd3
   } kf_state_e;

endpackage

// File: rtl/kf_wdog.sv
// Clearable up-counter; tc_o flags the TIMEOUT-th counted cycle since the last clear.
module kf_wdog #(
   parameter int unsigned TIMEOUT = 48
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int unsigned W = $clog2(TIMEOUT + 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc_o = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/kf_frame_sequencer.sv
// Frame sequencer for top_kf: accepts a measurement frame, launches the filter,
// captures the posterior state, loops it back as x_prev and presents the estimate.
module kf_frame_sequencer
   import kf_pkg::*;
#(
   parameter int unsigned  N       = KF_N,
   parameter int unsigned  FRAC    = KF_FRAC,
   parameter int unsigned  TIMEOUT = 48,
   parameter logic [N-1:0] X0_00   = '0,
   parameter logic [N-1:0] X0_10   = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         meas_valid,
   output logic         meas_ready,
   input  logic         meas_first,
   input  logic [N-1:0] meas_z00,
   input  logic [N-1:0] meas_z10,
   input  logic [N-1:0] meas_u00,
   input  logic [N-1:0] meas_u10,
   output logic         kf_start,
   output logic [N-1:0] kf_z00,
   output logic [N-1:0] kf_z10,
   output logic [N-1:0] kf_u00,
   output logic [N-1:0] kf_u10,
   output logic [N-1:0] kf_x00_prev,
   output logic [N-1:0] kf_x10_prev,
   input  logic         kf_done,
   input  logic [N-1:0] kf_x00_post,
   input  logic [N-1:0] kf_x10_post,
   output logic         est_valid,
   input  logic         est_ready,
   output logic [N-1:0] est_x00,
   output logic [N-1:0] est_x10,
   output logic [15:0]  est_seq,
   output logic         err_timeout,
   input  logic         err_clr,
   output logic         busy
);

   kf_state_e    state_q, state_d;
   logic [N-1:0] z00_q, z00_d, z10_q, z10_d, u00_q, u00_d, u10_q, u10_d;
   logic [N-1:0] xp00_q, xp00_d, xp10_q, xp10_d;
   logic [N-1:0] ex00_q, ex00_d, ex10_q, ex10_d;
   logic [15:0]  seq_q, seq_d, est_seq_q, est_seq_d;
   logic         err_q, err_d;
   logic         wd_clr, wd_tc, timeout_hit;
   logic         unused_frac;

   // FRAC only documents the Q format of the passed-through words.
   assign unused_frac = (FRAC < N) ^ (KF_ONE > 0);

   // Watchdog runs from the launch cycle so its terminal count lines up with kf_start.
   kf_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (wd_clr),
      .en_i  ((state_q == ST_LAUNCH) || (state_q == ST_WAIT)),
      .tc_o  (wd_tc)
   );

   always_comb begin
      state_d     = state_q;
      z00_d       = z00_q;
      z10_d       = z10_q;
      u00_d       = u00_q;
      u10_d       = u10_q;
      xp00_d      = xp00_q;
      xp10_d      = xp10_q;
      ex00_d      = ex00_q;
      ex10_d      = ex10_q;
      seq_d       = seq_q;
      est_seq_d   = est_seq_q;
      wd_clr      = 1'b0;
      timeout_hit = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (meas_valid) begin
               z00_d  = meas_z00;
               z10_d  = meas_z10;
               u00_d  = meas_u00;
               u10_d  = meas_u10;
               wd_clr = 1'b1;
               if (meas_first) begin
                  xp00_d = X0_00;
                  xp10_d = X0_10;
               end
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: state_d = ST_WAIT;
         ST_WAIT: begin
            if (kf_done) begin
               ex00_d    = kf_x00_post;
               ex10_d    = kf_x10_post;
               xp00_d    = kf_x00_post;
               xp10_d    = kf_x10_post;
               est_seq_d = seq_q;
               seq_d     = seq_q + 16'd1;
               state_d   = ST_EMIT;
            end else if (wd_tc) begin
               timeout_hit = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_EMIT: if (est_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      err_d = err_q;
      if (err_clr)     err_d = 1'b0;
      if (timeout_hit) err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         z00_q     <= '0;
         z10_q     <= '0;
         u00_q     <= '0;
         u10_q     <= '0;
         xp00_q    <= X0_00;
         xp10_q    <= X0_10;
         ex00_q    <= '0;
         ex10_q    <= '0;
         seq_q     <= '0;
         est_seq_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         z00_q     <= z00_d;
         z10_q     <= z10_d;
         u00_q     <= u00_d;
         u10_q     <= u10_d;
         xp00_q    <= xp00_d;
         xp10_q    <= xp10_d;
         ex00_q    <= ex00_d;
         ex10_q    <= ex10_d;
         seq_q     <= seq_d;
         est_seq_q <= est_seq_d;
         err_q     <= err_d;
      end
   end

   assign meas_ready  = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign kf_start    = (state_q == ST_LAUNCH);
   assign est_valid   = (state_q == ST_EMIT);
   assign kf_z00      = z00_q;
   assign kf_z10      = z10_q;
   assign kf_u00      = u00_q;
   assign kf_u10      = u10_q;
   assign kf_x00_prev = xp00_q;
   assign kf_x10_prev = xp10_q;
   assign est_x00     = ex00_q;
   assign est_x10     = ex10_q;
   assign est_seq     = est_seq_q;
   assign err_timeout = err_q;

endmodule
